// File: rtl/mode_pkg.sv
// Shared definitions for the mode selector: FSM states, segment patterns and mode width.
package mode_pkg;

   typedef enum logic [0:0] {
      StSelect = 1'b0,
      StLocked = 1'b1
   } state_e;

   localparam logic [6:0] SegBlank = 7'h00;
   localparam logic [6:0] SegDig0  = 7'h3F;
   localparam logic [6:0] SegDig1  = 7'h06;
   localparam logic [6:0] SegDig2  = 7'h5B;
   localparam logic [6:0] SegDig3  = 7'h4F;
   localparam logic [6:0] SegDig4  = 7'h66;
   localparam logic [6:0] SegDig5  = 7'h6D;
   localparam logic [6:0] SegDig6  = 7'h7D;
   localparam logic [6:0] SegDig7  = 7'h07;

   // Width of the mode register; never narrower than one bit.
   function automatic int unsigned mode_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Seven-segment pattern for a digit, seg[0]=a ... seg[6]=g.
   function automatic logic [6:0] seg_digit(input logic [2:0] d);
      logic [6:0] s;
      unique case (d)
         3'd0:    s = SegDig0;
         3'd1:    s = SegDig1;
         3'd2:    s = SegDig2;
         3'd3:    s = SegDig3;
         3'd4:    s = SegDig4;
         3'd5:    s = SegDig5;
         3'd6:    s = SegDig6;
         default: s = SegDig7;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, counting debouncer and rising-edge press pulse.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            press_q, press_d;

   // Count consecutive cycles the synchronized level disagrees with the accepted level.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntLast) begin
            level_d = sync2_q;
            press_d = sync2_q;  // pulse only on the accepted 0->1 change
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   // Synchronizer, debounce and pulse state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/mode_select_display.sv
// Game-mode selector: two debounced buttons step and lock a mode shown on a blinking 7-seg digit.
module mode_select_display
   import mode_pkg::*;
#(
   parameter int unsigned N_MODES         = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned BLINK_CYCLES    = 12500000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        btn_next,
   input  logic                        btn_confirm,
   input  logic                        game_over,
   output logic [mode_w(N_MODES)-1:0]  mode,
   output logic                        locked,
   output logic [6:0]                  seg
);

   localparam int unsigned ModeW  = mode_w(N_MODES);
   localparam int unsigned BlinkW = $clog2(BLINK_CYCLES + 1);
   localparam logic [ModeW-1:0]  ModeLast  = ModeW'(N_MODES - 1);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);

   logic next_p, confirm_p;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_next (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_next),
      .press_o (next_p)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_confirm (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_confirm),
      .press_o (confirm_p)
   );

   state_e            state_q, state_d;
   logic [ModeW-1:0]  mode_q, mode_d;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic              blink_on_q, blink_on_d;
   logic              locked_q;
   logic [6:0]        seg_q, seg_d;

   // Next-state: confirm beats next; any mode change or return to select restarts the blink.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      unique case (state_q)
         StSelect: begin
            if (confirm_p) begin
               state_d = StLocked;
            end else if (next_p) begin
               mode_d      = (mode_q == ModeLast) ? '0 : mode_q + ModeW'(1);
               blink_cnt_d = '0;
               blink_on_d  = 1'b1;
            end else if (blink_cnt_q == BlinkLast) begin
               blink_cnt_d = '0;
               blink_on_d  = ~blink_on_q;
            end else begin
               blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
         end
         StLocked: begin
            if (game_over) begin
               state_d     = StSelect;
               blink_cnt_d = '0;
               blink_on_d  = 1'b1;
            end
         end
         default: state_d = StSelect;
      endcase
      seg_d = (state_d == StLocked || blink_on_d) ? seg_digit(3'(mode_d)) : SegBlank;
   end

   // FSM, blink timer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StSelect;
         mode_q      <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         locked_q    <= 1'b0;
         seg_q       <= SegBlank;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         locked_q    <= (state_d == StLocked);
         seg_q       <= seg_d;
      end
   end

   assign mode   = mode_q;
   assign locked = locked_q;
   assign seg    = seg_q;

endmodule

// File: tb/tb_mode_select_display.sv
// Scoreboard bench for mode_select_display with a cycle-level behavioural reference model.
module tb_mode_select_display;

   localparam int N   = 3;
   localparam int DEB = 4;
   localparam int BLK = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_next = 1'b0;
   logic       btn_confirm = 1'b0;
   logic       game_over = 1'b0;
   logic [1:0] mode;
   logic       locked;
   logic [6:0] seg;

   mode_select_display #(
      .N_MODES         (N),
      .DEBOUNCE_CYCLES (DEB),
      .BLINK_CYCLES    (BLK)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_next    (btn_next),
      .btn_confirm (btn_confirm),
      .game_over   (game_over),
      .mode        (mode),
      .locked      (locked),
      .seg         (seg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] mode;
      logic       locked;
      logic [6:0] seg;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;

   logic [6:0] digits [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

   // Reference model state.
   int           m_mode;
   bit           m_locked;
   int           m_since;   // edges since the blink last restarted
   bit [DEB+1:0] h_n, h_c;  // raw button history, bit 0 = current edge
   bit           db_n, db_c, rise_n, rise_c;

   function automatic void model_reset();
      m_mode   = 0;
      m_locked = 1'b0;
      m_since  = 0;
      h_n = '0;
      h_c = '0;
      db_n = 1'b0;
      db_c = 1'b0;
      rise_n = 1'b0;
      rise_c = 1'b0;
   endfunction

   // A level is accepted once the DEB synchronized samples (raw delayed two edges) all disagree.
   task automatic deb_model(input bit raw, inout bit [DEB+1:0] h, inout bit db, output bit rise);
      bit [DEB-1:0] w;
      h = {h[DEB:0], raw};
      w = h[DEB+1:2];
      rise = 1'b0;
      if (db ? (w == '0) : (&w)) begin
         db   = ~db;
         rise = db;
      end
   endtask

   task automatic model_edge(input bit n, input bit c, input bit g, output exp_t e);
      bit pn, pc, on;
      pn = rise_n;
      pc = rise_c;
      if (!m_locked) begin
         if (pc) begin
            m_locked = 1'b1;
         end else if (pn) begin
            m_mode  = (m_mode + 1) % N;
            m_since = 0;
         end else begin
            m_since++;
         end
      end else if (g) begin
         m_locked = 1'b0;
         m_since  = 0;
      end
      deb_model(n, h_n, db_n, rise_n);
      deb_model(c, h_c, db_c, rise_c);
      on       = ((m_since / BLK) % 2) == 0;
      e.mode   = 2'(m_mode);
      e.locked = m_locked;
      e.seg    = (m_locked || on) ? digits[m_mode] : 7'h00;
   endtask

   task automatic step(input bit n, input bit c, input bit g);
      exp_t e;
      btn_next    = n;
      btn_confirm = c;
      game_over   = g;
      model_edge(n, c, g, e);
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic hold(input bit n, input bit c, input int cycles);
      for (int i = 0; i < cycles; i++) step(n, c, 1'b0);
   endtask

   task automatic check_now(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // Monitor: one registered output set per cycle, compared at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (mode !== e.mode || locked !== e.locked || seg !== e.seg) begin
               fails++;
               $display("FAIL outputs @%0t: mode=%0d locked=%0b seg=%h, expected mode=%0d locked=%0b seg=%h",
                        $time, mode, locked, seg, e.mode, e.locked, e.seg);
            end
         end
      end
   end

   initial begin
      bit n, c;
      int len;
      model_reset();
      #3;
      check_now("reset_mode", int'(mode), 0);
      check_now("reset_locked", int'(locked), 0);
      check_now("reset_seg", int'(seg), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle blinking of mode 0.
      hold(0, 0, 24);

      // Three full presses: 1, 2, wrap to 0.
      for (int p = 0; p < 3; p++) begin
         hold(1, 0, 10);
         hold(0, 0, 10);
      end

      // Short glitch must be rejected.
      hold(1, 0, 3);
      hold(0, 0, 10);

      // Step to mode 1, then next+confirm together locks.
      hold(1, 0, 10);
      hold(0, 0, 10);
      hold(1, 1, 10);
      hold(0, 0, 10);

      // Next ignored while locked; game_over unlocks with blink restarted.
      hold(1, 0, 10);
      hold(0, 0, 10);
      step(0, 0, 1);
      hold(0, 0, 20);

      // Randomized button levels and game_over pulses.
      repeat (40) begin
         n   = 1'($urandom_range(0, 1));
         c   = ($urandom_range(0, 3) == 0);
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) step(n, c, ($urandom_range(0, 15) == 0));
      end
      hold(0, 0, 10);

      // Drive the model to locked at mode 2.
      for (int k = 0; k < 20 && !(m_locked && m_mode == 2); k++) begin
         if (m_locked) begin
            step(0, 0, 1);
            hold(0, 0, 2);
         end else if (m_mode != 2) begin
            hold(1, 0, 10);
            hold(0, 0, 10);
         end else begin
            hold(0, 1, 10);
            hold(0, 0, 10);
         end
      end

      // Start a press, then reset mid-debounce with no clock edge.
      hold(1, 0, 3);
      @(negedge clk);
      #1;
      btn_next = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_now("async_rst_mode", int'(mode), 0);
      check_now("async_rst_locked", int'(locked), 0);
      check_now("async_rst_seg", int'(seg), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      hold(0, 0, 20);

      @(negedge clk);
      #1;
      check_now("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
